// File: rtl/riot_bus_master.sv
// riot_bus_master
// Command-driven bus initiator for a RIOT (6532). It turns single-beat
// commands into exact one-cycle RIOT accesses, so side-effecting reads
// (timer, interrupt flags) happen exactly once per command.
//
// Ports
//   CLK, RES_n          clock (posedge) and asynchronous active-low reset
//   cmd_*               command channel (valid/ready), ops: 0 READ, 1 WRITE,
//                       2 POLL_IRQ, 3 FILL
//   rsp_*               response channel (valid/ready), read data + timeout
//   A, Dout, Din        RIOT address, write data, read data
//   CS, CS_n, R_W_n,
//   RS_n                RIOT selects and read/write strobe
//   IRQ_n               RIOT interrupt, same clock domain
//   dbg_state_o         current FSM state for observation
//
// Handshake: a transfer happens on the rising CLK edge where valid and
// ready are both high; valid, once raised, holds its payload stable until
// that edge, and ready never depends combinationally on valid.
module riot_bus_master (
    input  logic       CLK,
    input  logic       RES_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_rs_n,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic [7:0] cmd_len,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [6:0] A,
    output logic [7:0] Dout,
    input  logic [7:0] Din,
    output logic       CS,
    output logic       CS_n,
    output logic       R_W_n,
    output logic       RS_n,
    input  logic       IRQ_n,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_RESP      = 3'd3,
        ST_POLL_WAIT = 3'd4,
        ST_FILL      = 3'd5
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_FILL  = 2'd3;

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_timeout_q;
    logic        cs_q;
    logic        cs_n_q;
    logic        rwn_q;
    logic        rsn_q;
    logic [6:0]  a_q;
    logic [7:0]  dout_q;
    logic        op_rs_n_q;   // RS_n for deferred poll read / fill beats
    logic [6:0]  op_addr_q;   // poll address, or next fill address
    logic [7:0]  op_data_q;   // fill data
    logic [7:0]  beat_q;      // fill beats still to issue
    logic [15:0] tmo_cnt_q;
    logic        tmo_en_q;

    logic [15:0] tmo_cnt_d;
    logic [6:0]  op_addr_d;
    logic [7:0]  beat_d;

    assign tmo_cnt_d = tmo_cnt_q - 16'd1;
    assign op_addr_d = op_addr_q + 7'd1;   // 7-bit wrap 7F -> 00
    assign beat_d    = beat_q - 8'd1;

    always_ff @(posedge CLK or negedge RES_n) begin
        if (!RES_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            cs_q          <= 1'b0;
            cs_n_q        <= 1'b1;
            rwn_q         <= 1'b1;
            rsn_q         <= 1'b1;
            a_q           <= 7'h00;
            dout_q        <= 8'h00;
            op_rs_n_q     <= 1'b1;
            op_addr_q     <= 7'h00;
            op_data_q     <= 8'h00;
            beat_q        <= 8'h00;
            tmo_cnt_q     <= 16'h0000;
            tmo_en_q      <= 1'b0;
        end else begin
            // Bus returns to idle every cycle unless a strobe is issued below,
            // which guarantees each access lasts exactly one cycle.
            cs_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rwn_q       <= 1'b1;
            rsn_q       <= 1'b1;
            a_q         <= 7'h00;
            dout_q      <= 8'h00;
            cmd_ready_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        case (cmd_op)
                            OP_READ, OP_WRITE: begin
                                cs_q    <= 1'b1;
                                cs_n_q  <= 1'b0;
                                rwn_q   <= (cmd_op == OP_READ);
                                rsn_q   <= cmd_rs_n;
                                a_q     <= cmd_addr;
                                dout_q  <= (cmd_op == OP_WRITE) ? cmd_data : 8'h00;
                                state_q <= ST_ISSUE;
                            end
                            OP_POLL: begin
                                op_rs_n_q <= cmd_rs_n;
                                op_addr_q <= cmd_addr;
                                tmo_cnt_q <= {cmd_len, 8'h00};
                                tmo_en_q  <= (cmd_len != 8'h00);
                                state_q   <= ST_POLL_WAIT;
                            end
                            default: begin  // OP_FILL: first beat issues now
                                cs_q      <= 1'b1;
                                cs_n_q    <= 1'b0;
                                rwn_q     <= 1'b0;
                                rsn_q     <= cmd_rs_n;
                                a_q       <= cmd_addr;
                                dout_q    <= cmd_data;
                                op_rs_n_q <= cmd_rs_n;
                                op_addr_q <= cmd_addr + 7'd1;
                                op_data_q <= cmd_data;
                                beat_q    <= cmd_len;
                                state_q   <= ST_FILL;
                            end
                        endcase
                    end
                end

                ST_ISSUE: begin
                    // rwn_q still describes the strobe that just completed.
                    if (rwn_q) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_CAPTURE: begin
                    rsp_data_q    <= Din;
                    rsp_timeout_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_POLL_WAIT: begin
                    // IRQ is checked first so it wins over a simultaneous timeout.
                    if (!IRQ_n) begin
                        cs_q    <= 1'b1;
                        cs_n_q  <= 1'b0;
                        rwn_q   <= 1'b1;
                        rsn_q   <= op_rs_n_q;
                        a_q     <= op_addr_q;
                        state_q <= ST_ISSUE;
                    end else if (tmo_en_q && (tmo_cnt_d == 16'h0000)) begin
                        tmo_cnt_q     <= tmo_cnt_d;
                        rsp_data_q    <= 8'h00;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end

                ST_FILL: begin
                    if (beat_q == 8'h00) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cs_q      <= 1'b1;
                        cs_n_q    <= 1'b0;
                        rwn_q     <= 1'b0;
                        rsn_q     <= op_rs_n_q;
                        a_q       <= op_addr_q;
                        dout_q    <= op_data_q;
                        op_addr_q <= op_addr_d;
                        beat_q    <= beat_d;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign CS          = cs_q;
    assign CS_n        = cs_n_q;
    assign R_W_n       = rwn_q;
    assign RS_n        = rsn_q;
    assign A           = a_q;
    assign Dout        = dout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riot_bus_master.sv
module tb_riot_bus_master;

  // ---------------------------------------------------------------- clock/reset
  logic       CLK = 1'b0;
  logic       RES_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_rs_n = 1'b1;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [6:0] A;
  logic [7:0] Dout;
  logic [7:0] Din = 8'h00;
  logic       CS, CS_n, R_W_n, RS_n;
  logic       IRQ_n;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  riot_bus_master dut (
    .CLK(CLK), .RES_n(RES_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs_n(cmd_rs_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .A(A), .Dout(Dout), .Din(Din),
    .CS(CS), .CS_n(CS_n), .R_W_n(R_W_n), .RS_n(RS_n),
    .IRQ_n(IRQ_n), .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------- RIOT stand-in
  typedef struct {
    int         t;
    logic       rw;
    logic       rs;
    logic [6:0] a;
    logic [7:0] d;
  } strobe_t;

  strobe_t    str_q[$];
  int         cyc = 0;
  int         strobe_cnt = 0;
  logic [7:0] ram [128] = '{default: 8'h00};
  logic [7:0] ddra = 8'h00;
  logic [7:0] tmr = 8'h00;
  logic       tmr_run = 1'b0;
  logic       tmr_flag = 1'b0;
  logic       tmr_ie = 1'b0;

  assign IRQ_n = !(tmr_flag && tmr_ie);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (tmr_run) begin
      if (tmr == 8'h00) begin
        tmr_flag <= 1'b1;
        tmr_run  <= 1'b0;
      end else begin
        tmr <= tmr - 8'h01;
      end
    end
    if (CS && !CS_n) begin
      strobe_cnt <= strobe_cnt + 1;
      str_q.push_back('{cyc, R_W_n, RS_n, A, Dout});
      if (!RS_n) begin
        if (!R_W_n) ram[A] <= Dout;
        else        Din <= ram[A];
      end else if (!A[2]) begin
        if (A[1:0] == 2'd1) begin
          if (!R_W_n) ddra <= Dout;
          else        Din <= ddra;
        end else if (R_W_n) begin
          Din <= 8'h00;
        end
      end else if (R_W_n) begin
        Din <= A[0] ? {tmr_flag, 7'b0} : tmr;
      end else if (A[4]) begin
        tmr      <= Dout;
        tmr_run  <= 1'b1;
        tmr_flag <= 1'b0;
        tmr_ie   <= A[3];
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [8:0] exp_q[$];   // {timeout, data}
  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------- driver tasks
  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue_cmd(input logic [1:0] op, input logic rs, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] len);
    int g;
    g = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rs_n = rs; cmd_addr = a; cmd_data = d; cmd_len = len;
    while (!cmd_ready && g < 1000) begin
      @(negedge CLK);
      g++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL accept_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, g);
      cmd_valid = 1'b0;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
    end
  endtask

  // Waits for a response, reports it and its latency in cycles from accept.
  task automatic get_rsp(output logic [7:0] d, output logic to, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(negedge CLK);
      lat++;
    end
    d  = rsp_data;
    to = rsp_timeout;
    if (rsp_valid && rsp_ready) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({CS, CS_n, R_W_n, RS_n, A, Dout} !== {4'b0111, 7'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_bus: CS/CS_n/R_W_n/RS_n/A/Dout=%b/%b/%b/%b/%h/%h, required 0/1/1/1/00/00",
               CS, CS_n, R_W_n, RS_n, A, Dout);
    end
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_timeout} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h timeout=%b, required 0 0 00 0",
               cmd_ready, rsp_valid, rsp_data, rsp_timeout);
    end
    RES_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b before first edge, required 0", cmd_ready);
    end
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_first_edge: cmd_ready=%b state=%0d, required 1 and 0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    logic       to;
    int         lat;
    int         s0;
    logic [8:0] e;
    logic [6:0] base;
    logic [7:0] pat [4];
    str_q.delete();
    s0 = strobe_cnt;
    issue_cmd(2'd1, 1'b1, 7'h01, 8'hFF, 8'h00);
    issue_cmd(2'd0, 1'b1, 7'h01, 8'h00, 8'h00);
    exp_q.push_back({1'b0, 8'hFF});
    get_rsp(d, to, lat);
    e = exp_q.pop_front();
    checks++;
    if ({to, d} !== e) begin
      failures++;
      $display("FAIL ddra_read: got %h, required %h", {to, d}, e);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL read_latency: got %0d cycles, required 2", lat);
    end
    checks++;
    if (strobe_cnt - s0 !== 2) begin
      failures++;
      $display("FAIL write_read_strobes: got %0d, required 2", strobe_cnt - s0);
    end
    checks++;
    if (str_q.size() < 2 || str_q[0].rw !== 1'b0 || str_q[0].d !== 8'hFF || str_q[0].a !== 7'h01 ||
        str_q[1].rw !== 1'b1 || str_q[1].rs !== 1'b1 || str_q[1].a !== 7'h01) begin
      failures++;
      $display("FAIL write_read_fields: strobe log size=%0d does not show write 01<=FF then read 01",
               str_q.size());
    end
    // Random RAM patterns through the scoreboard.
    base = 7'($urandom_range(32, 48));
    for (int i = 0; i < 4; i++) begin
      pat[i] = 8'($urandom_range(0, 255));
      issue_cmd(2'd1, 1'b0, base + 7'(i * 3), pat[i], 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      issue_cmd(2'd0, 1'b0, base + 7'(i * 3), 8'h00, 8'h00);
      exp_q.push_back({1'b0, pat[i]});
      get_rsp(d, to, lat);
      e = exp_q.pop_front();
      checks++;
      if ({to, d} !== e) begin
        failures++;
        $display("FAIL ram_read_%0d: got %h, required %h", i, {to, d}, e);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    logic       to;
    int         lat;
    logic [8:0] e;
    logic [6:0] ea [4];
    logic [6:0] ra [3];
    ea[0] = 7'h7E; ea[1] = 7'h7F; ea[2] = 7'h00; ea[3] = 7'h01;
    ra[0] = 7'h7E; ra[1] = 7'h01; ra[2] = 7'h02;
    str_q.delete();
    issue_cmd(2'd3, 1'b0, 7'h7E, 8'hA5, 8'd3);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 3; i++) begin
      issue_cmd(2'd0, 1'b0, ra[i], 8'h00, 8'h00);
      get_rsp(d, to, lat);
      e = exp_q.pop_front();
      checks++;
      if ({to, d} !== e) begin
        failures++;
        $display("FAIL fill_readback_%0d: got %h, required %h", i, {to, d}, e);
      end
    end
    checks++;
    if (str_q.size() !== 7) begin
      failures++;
      $display("FAIL fill_strobe_count: got %0d, required 7", str_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (str_q[i].a !== ea[i] || str_q[i].rw !== 1'b0 || str_q[i].rs !== 1'b0 ||
            str_q[i].d !== 8'hA5 || (i > 0 && str_q[i].t !== str_q[0].t + i)) begin
          failures++;
          $display("FAIL fill_beat_%0d: a=%h rw=%b rs=%b d=%h t=%0d, required a=%h 0 0 A5 t=%0d",
                   i, str_q[i].a, str_q[i].rw, str_q[i].rs, str_q[i].d, str_q[i].t, ea[i],
                   str_q[0].t + i);
        end
      end
    end
  endtask

  task automatic test_poll_irq();
    logic [7:0] d;
    logic       to;
    int         lat;
    int         s0;
    logic [8:0] e;
    s0 = strobe_cnt;
    issue_cmd(2'd1, 1'b1, 7'h1C, 8'h05, 8'h00);
    issue_cmd(2'd2, 1'b1, 7'h05, 8'h00, 8'd1);
    exp_q.push_back({1'b0, 8'h80});
    get_rsp(d, to, lat);
    e = exp_q.pop_front();
    checks++;
    if ({to, d} !== e) begin
      failures++;
      $display("FAIL poll_irq_rsp: got %h, required %h", {to, d}, e);
    end
    checks++;
    if (lat < 3 || lat > 11) begin
      failures++;
      $display("FAIL poll_irq_latency: got %0d cycles, required 3..11", lat);
    end
    checks++;
    if (strobe_cnt - s0 !== 2 || str_q[$].a !== 7'h05 || str_q[$].rw !== 1'b1) begin
      failures++;
      $display("FAIL poll_irq_strobes: count=%0d last a=%h rw=%b, required 2, 05, 1",
               strobe_cnt - s0, str_q[$].a, str_q[$].rw);
    end
    // IRQ still asserted: poll completes with minimum latency.
    s0 = strobe_cnt;
    issue_cmd(2'd2, 1'b1, 7'h05, 8'h00, 8'd0);
    exp_q.push_back({1'b0, 8'h80});
    get_rsp(d, to, lat);
    e = exp_q.pop_front();
    checks++;
    if ({to, d} !== e || lat !== 3 || strobe_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL poll_irq_low: rsp=%h lat=%0d strobes=%0d, required %h 3 1",
               {to, d}, lat, strobe_cnt - s0, e);
    end
  endtask

  task automatic test_poll_timeout();
    logic [7:0] d;
    logic       to;
    int         lat;
    int         s0;
    logic [8:0] e;
    issue_cmd(2'd1, 1'b1, 7'h14, 8'hFF, 8'h00);  // re-arm with interrupt disabled
    @(negedge CLK);
    s0 = strobe_cnt;
    issue_cmd(2'd2, 1'b1, 7'h05, 8'h00, 8'd1);
    exp_q.push_back({1'b1, 8'h00});
    get_rsp(d, to, lat);
    e = exp_q.pop_front();
    checks++;
    if ({to, d} !== e) begin
      failures++;
      $display("FAIL poll_timeout_rsp: got %h, required %h", {to, d}, e);
    end
    checks++;
    if (lat !== 256) begin
      failures++;
      $display("FAIL poll_timeout_latency: got %0d cycles, required 256", lat);
    end
    checks++;
    if (strobe_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL poll_timeout_strobes: got %0d, required 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    logic       to;
    int         lat;
    int         s0;
    logic [8:0] e;
    s0 = strobe_cnt;
    rsp_ready = 1'b0;
    issue_cmd(2'd0, 1'b1, 7'h01, 8'h00, 8'h00);
    exp_q.push_back({1'b0, 8'hFF});
    get_rsp(d, to, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_timeout !== to || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d: valid=%b data=%h ready=%b, required 1 %h 0",
                 i, rsp_valid, rsp_data, cmd_ready, d);
      end
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: valid=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
    e = exp_q.pop_front();
    checks++;
    if ({to, d} !== e || strobe_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL stall_data: rsp=%h strobes=%0d, required %h 1", {to, d}, strobe_cnt - s0, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       to;
    int         lat;
    logic [8:0] e;
    str_q.delete();
    for (int i = 0; i < 2; i++) begin
      issue_cmd(2'd0, 1'b0, 7'h7E + 7'(i), 8'h00, 8'h00);
      exp_q.push_back({1'b0, 8'hA5});
      get_rsp(d, to, lat);
      e = exp_q.pop_front();
      checks++;
      if ({to, d} !== e) begin
        failures++;
        $display("FAIL b2b_data_%0d: got %h, required %h", i, {to, d}, e);
      end
    end
    checks++;
    if (str_q.size() !== 2 || str_q[1].t - str_q[0].t !== 4) begin
      failures++;
      $display("FAIL b2b_spacing: strobes=%0d spacing=%0d, required 2 and 4", str_q.size(),
               (str_q.size() == 2) ? str_q[1].t - str_q[0].t : -1);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    logic       to;
    int         lat;
    int         s0;
    int         g;
    logic [8:0] e;
    s0 = strobe_cnt;
    g = 0;
    issue_cmd(2'd3, 1'b0, 7'h10, 8'h3C, 8'h10);
    while (strobe_cnt - s0 < 5 && g < 100) begin
      @(negedge CLK);
      g++;
    end
    RES_n = 1'b0;
    #1;
    checks++;
    if ({CS, CS_n, R_W_n, RS_n, A, Dout} !== {4'b0111, 7'h00, 8'h00} ||
        rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL midfill_reset_idle: CS=%b CS_n=%b A=%h valid=%b ready=%b state=%0d, required idle",
               CS, CS_n, A, rsp_valid, cmd_ready, dbg_state);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (strobe_cnt - s0 !== 5) begin
      failures++;
      $display("FAIL midfill_beats: got %0d strobes, required 5", strobe_cnt - s0);
    end
    RES_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midfill_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 2; i++) begin
      issue_cmd(2'd0, 1'b0, (i == 0) ? 7'h12 : 7'h15, 8'h00, 8'h00);
      get_rsp(d, to, lat);
      e = exp_q.pop_front();
      checks++;
      if ({to, d} !== e) begin
        failures++;
        $display("FAIL midfill_read_%0d: got %h, required %h", i, {to, d}, e);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_poll_irq();
    test_poll_timeout();
    test_stall();
    test_back_to_back();
    test_reset_mid_fill();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riot_bus_master.md
# riot_bus_master

Command-driven bus initiator for the RIOT (6532) peripheral. It turns single-beat commands from a loader, debug port or self-test engine into cycle-exact RIOT bus accesses: reads, writes, RAM fills, and IRQ-wait-then-read polls. It sits in place of, or muxed with, the CPU on the RIOT address/data/select pins. Every access is exactly one strobe cycle, so side-effecting reads (timer, interrupt flag) fire once.

## Interface
- No parameters.
- CLK  in  1  single system clock; all logic on posedge
- RES_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted on posedge when valid&ready
- cmd_op  in  2  0 READ, 1 WRITE, 2 POLL_IRQ, 3 FILL
- cmd_rs_n  in  1  value driven on RS_n (0 = RAM, 1 = I/O/timer)
- cmd_addr  in  7  start address
- cmd_data  in  8  write/fill data
- cmd_len  in  8  FILL: beats-1; POLL_IRQ: timeout in 256-cycle units, 0 = no timeout
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response consumed on posedge when valid&ready
- rsp_data  out  8  read data (0 on timeout)
- rsp_timeout  out  1  POLL_IRQ ended by timeout
- A  out  7  RIOT address
- Dout  out  8  RIOT write data (to RIOT Din)
- Din  in  8  RIOT read data (from RIOT Dout)
- CS, CS_n, R_W_n, RS_n  out  1 each  RIOT selects/strobe
- IRQ_n  in  1  RIOT interrupt, same clock domain, no synchroniser

## Operation
- All outputs registered. Idle bus: CS=0, CS_n=1, R_W_n=1, RS_n=1, A=0, Dout=0. Access cycle: CS=1, CS_n=0, A/RS_n/R_W_n/Dout from command, exactly one cycle.
- States: IDLE, ISSUE, CAPTURE, RESP, POLL_WAIT, FILL.
- READ: IDLE -> ISSUE (R_W_n=1) -> CAPTURE (bus idle; Din latched into rsp_data at end) -> RESP -> IDLE on rsp_ready.
- WRITE: IDLE -> ISSUE (R_W_n=0, Dout=cmd_data) -> IDLE. No response.
- FILL: cmd_len+1 back-to-back write cycles to A = cmd_addr, +1, ...; address 7-bit, wraps 7'h7F -> 7'h00; RS_n = cmd_rs_n. Then IDLE, no response.
- POLL_IRQ: POLL_WAIT samples IRQ_n each posedge. IRQ_n=0 -> ISSUE a read of cmd_addr, then CAPTURE/RESP as READ with rsp_timeout=0. 16-bit counter loaded {cmd_len,8'h00}, decremented per POLL_WAIT cycle; reaching 0 (cmd_len != 0) -> RESP with rsp_data=0, rsp_timeout=1, no bus access. IRQ_n low and timeout on the same edge: IRQ wins.
- rsp_valid=1 only in RESP; rsp_data/rsp_timeout stable while rsp_valid.
- Reset (any state): async to IDLE, bus idle, rsp_valid=0, rsp_data=0, rsp_timeout=0, counters 0, cmd_ready=0 while RES_n low, 1 from first posedge after release. Any in-flight command or response is discarded, including a partial FILL.

## Timing
- Accept edge E0. Bus strobe cycle E0..E1; RIOT acts at E1. READ: Din captured and rsp_valid=1 after E2 (2-cycle latency). WRITE: cmd_ready=1 again after E1.
- FILL of N beats: strobes E0..EN, cmd_ready after EN, no gap cycles.
- POLL_IRQ with IRQ_n already low: first POLL_WAIT sample at E1, strobe E1..E2, rsp_valid after E3.
- rsp_ready may be high when rsp_valid rises: response consumed same edge, IDLE next cycle. Back-to-back READs: 4 cycles minimum per command (accept, issue, capture, resp).

## Test plan
- WRITE rs_n=1 addr 7'h01 data 8'hFF (DDRA), then READ same -> rsp_data=8'hFF, rsp_valid 2 cycles after accept, one CS strobe per command.
- FILL rs_n=0 addr 7'h7E len 3 data 8'hA5 -> 4 consecutive strobes at A=7E,7F,00,01; READs of 7'h7E, 7'h01 return A5, 7'h02 returns 00.
- WRITE rs_n=1 addr 7'h1C data 8'h05 (timer, /1, IRQ enabled), then POLL_IRQ addr 7'h05 len 1 -> IRQ_n falls within 8 cycles, rsp_data[7]=1, rsp_timeout=0, exactly one flag-register strobe.
- POLL_IRQ len 1 with no timer armed -> rsp_valid after 256 wait cycles, rsp_timeout=1, rsp_data=0, no strobe issued.
- READ with rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout, single strobe.
- RES_n pulsed low mid-FILL (len 8'h10, beat 5) -> bus idle immediately, rsp_valid=0; after release cmd_ready=1 and new READ works.
